// File: rtl/imem_loader.sv
// imem_loader
//
// Boot-time program loader for the single-cycle MIPS computer. A byte stream
// arrives over a valid/ready handshake. The loader packs it little-endian into
// 32-bit instruction words, writes each word into instruction memory, and then
// checks a trailing checksum byte. The CPU is held in reset until the program
// has been loaded and validated, and for HOLD_CYCLES cycles after that.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       synchronous active-high reset
//   start       single-cycle request to begin a load
//   len         number of words to load, sampled when start is accepted
//   byte_in     stream data byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle (registered state decode)
//   imem_we     instruction memory write strobe (one-cycle pulse per word)
//   imem_addr   instruction memory word address
//   imem_wd     instruction memory write data
//   cpu_reset   active-high reset to the CPU, low only in RUN
//   busy        high in LOAD, CSUM and HOLD
//   done        high in RUN
//   err         high in ERROR
module imem_loader #(
  parameter int N           = 32,
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wd,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CSUM  = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [AW:0] LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  state_t      start_target;
  logic [AW:0] len_q;
  logic [AW:0] word_idx;
  logic [1:0]  lane;
  logic [7:0]  acc;
  logic [23:0] word_buf;
  logic [7:0]  hold_cnt;
  logic [7:0]  csum_sum;
  logic        xfer;
  logic        last_word;

  assign xfer      = byte_valid & byte_ready;
  assign csum_sum  = acc + byte_in;
  assign last_word = (word_idx == (len_q - ONE));

  // Where a freshly accepted start request leads, based on the requested length.
  always_comb begin
    start_target = LOAD;
    if (len == '0)
      start_target = HOLD;
    else if (len > LEN_MAX)
      start_target = ERROR;
  end

  // Next-state decode. The registered outputs below are decoded from this, so
  // byte_ready/cpu_reset/busy/done/err always describe the state being entered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, ERROR: if (start) state_nxt = start_target;
      LOAD:             if (xfer && lane == 2'd3 && last_word) state_nxt = CSUM;
      CSUM:             if (xfer) state_nxt = (csum_sum == 8'd0) ? HOLD : ERROR;
      HOLD:             if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      default:          state_nxt = IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      word_idx   <= '0;
      lane       <= '0;
      acc        <= '0;
      word_buf   <= '0;
      hold_cnt   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wd    <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      imem_we    <= 1'b0;
      byte_ready <= (state_nxt == LOAD) || (state_nxt == CSUM);
      busy       <= (state_nxt == LOAD) || (state_nxt == CSUM) || (state_nxt == HOLD);
      done       <= (state_nxt == RUN);
      err        <= (state_nxt == ERROR);
      cpu_reset  <= (state_nxt != RUN);

      case (state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            len_q    <= len;
            word_idx <= '0;
            lane     <= '0;
            acc      <= '0;
            hold_cnt <= '0;
          end
        end

        LOAD: begin
          if (xfer) begin
            acc  <= acc + byte_in;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= byte_in;
              2'd1: word_buf[15:8]  <= byte_in;
              2'd2: word_buf[23:16] <= byte_in;
              default: begin
                // Fourth byte completes the word: it goes straight to the
                // write port rather than through word_buf.
                imem_wd   <= {byte_in, word_buf};
                imem_addr <= word_idx[AW-1:0];
                imem_we   <= 1'b1;
                word_idx  <= word_idx + ONE;
              end
            endcase
          end
        end

        CSUM: begin
          if (xfer) begin
            acc      <= csum_sum;
            hold_cnt <= '0;
          end
        end

        HOLD: hold_cnt <= hold_cnt + 8'd1;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//
// Directed testbench for imem_loader. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed expectations.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge or 1 time unit after the rising edge.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  int rdy_viol = 0;

  logic [31:0] prog [0:63];
  logic [5:0]  wa [$];
  logic [31:0] wd [$];

  imem_loader #(.N(32), .DEPTH(64), .AW(AW), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every memory write, and flag byte_ready outside LOAD/CSUM.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wd);
    end
    if (byte_ready === 1'b1 && (busy !== 1'b1 || done === 1'b1 || err === 1'b1))
      rdy_viol++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] get_byte(input int k);
    logic [31:0] w;
    w = prog[k/4];
    return w[8*(k%4) +: 8];
  endfunction

  function automatic logic [7:0] checksum(input int nwords);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 4*nwords; k++) s = s + get_byte(k);
    return 8'h00 - s;
  endfunction

  task automatic clear_log;
    wa.delete();
    wd.delete();
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin byte_valid = 1'b0; @(negedge clk); end
    byte_in = b; byte_valid = 1'b1; t = 0;
    while (byte_ready !== 1'b1 && t < 64) begin @(negedge clk); t++; end
    if (byte_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("[TB] FAIL byte_ready_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_program(input int n, input logic [7:0] adj, input int gapmax);
    for (int k = 0; k < 4*n; k++)
      send_byte(get_byte(k), (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    send_byte(checksum(n) + adj, 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_reset, byte_ready, imem_we, imem_addr, imem_wd, busy, done, err} !==
        {1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %h required %h",
               {cpu_reset, byte_ready, imem_we, imem_addr, imem_wd, busy, done, err},
               {1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 3'b000});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_reset, byte_ready, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL idle_outputs: got %b required 100", {cpu_reset, byte_ready, busy});
    end
  endtask

  task automatic test_single_word;
    do_reset; clear_log;
    pulse_start(7'd1);
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h20, 0);
    vectors++;
    if ({imem_we, imem_addr, imem_wd, byte_ready} !== {1'b1, 6'd0, 32'h20020005, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL single_write: got %h required %h",
               {imem_we, imem_addr, imem_wd, byte_ready}, {1'b1, 6'd0, 32'h20020005, 1'b1});
    end
    send_byte(8'hD9, 0);
    vectors++;
    if ({cpu_reset, busy, done} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL hold_entry: got %b required 110", {cpu_reset, busy, done});
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (cpu_reset !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: cpu_reset=%b required 1", k, cpu_reset);
      end
    end
    @(negedge clk);
    vectors++;
    if ({cpu_reset, done, err} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL run_entry: got %b required 010", {cpu_reset, done, err});
    end
    vectors++;
    if (wa.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL single_write_count: got %0d required 1", wa.size());
    end
  endtask

  task automatic test_bad_checksum;
    bit ok;
    do_reset; clear_log;
    prog[0] = 32'h20020005;
    pulse_start(7'd1);
    send_program(1, 8'hFF, 0);
    vectors++;
    if ({err, cpu_reset, done, byte_ready} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL bad_csum: got %b required 1100", {err, cpu_reset, done, byte_ready});
    end
    repeat (6) @(negedge clk);
    vectors++;
    if ({err, cpu_reset} !== 2'b11 || wa.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL error_sticky: err/cpu_reset=%b writes=%0d required 11 and 1",
               {err, cpu_reset}, wa.size());
    end
    clear_log;
    prog[0] = 32'h2003000C;
    pulse_start(7'd1);
    send_program(1, 8'h00, 0);
    wait_done(ok);
    vectors++;
    if (!ok || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL error_recover: done_seen=%0d err=%b required 1 and 0", ok, err);
    end
    vectors++;
    if (wa.size() != 1 || wd[0] !== 32'h2003000C) begin
      miscompares++;
      $display("[TB] FAIL error_recover_write: writes=%0d data=%h required 1 and 2003000c",
               wa.size(), (wa.size() > 0) ? wd[0] : 32'hx);
    end
  endtask

  task automatic test_random_valid;
    bit ok;
    logic [31:0] exp_w [0:2];
    exp_w[0] = 32'h20020005; exp_w[1] = 32'h2003000C; exp_w[2] = 32'h2067FFF7;
    do_reset; clear_log; rdy_viol = 0;
    for (int i = 0; i < 3; i++) prog[i] = exp_w[i];
    pulse_start(7'd3);
    send_program(3, 8'h00, 3);
    wait_done(ok);
    vectors++;
    if (!ok || wa.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL gapped_load: done_seen=%0d writes=%0d required 1 and 3", ok, wa.size());
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (((i < wa.size()) ? {wa[i], wd[i]} : 38'hx) !== {6'(i), exp_w[i]}) begin
        miscompares++;
        $display("[TB] FAIL gapped_word%0d: got %h required %h", i,
                 (i < wa.size()) ? {wa[i], wd[i]} : 38'hx, {6'(i), exp_w[i]});
      end
    end
    vectors++;
    if (rdy_viol != 0) begin
      miscompares++;
      $display("[TB] FAIL ready_outside_load: got %0d cycles required 0", rdy_viol);
    end
  endtask

  task automatic test_len_zero;
    do_reset; clear_log;
    pulse_start(7'd0);
    vectors++;
    if ({cpu_reset, busy, byte_ready} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL len0_hold: got %b required 110", {cpu_reset, busy, byte_ready});
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({cpu_reset, byte_ready} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL len0_cycle%0d: got %b required 10", k, {cpu_reset, byte_ready});
      end
    end
    @(negedge clk);
    vectors++;
    if ({cpu_reset, done, wa.size() == 0} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL len0_run: cpu_reset/done=%b writes=%0d required 01 and 0",
               {cpu_reset, done}, wa.size());
    end
  endtask

  task automatic test_len_overflow;
    do_reset;
    pulse_start(7'd65);
    vectors++;
    if ({err, busy, cpu_reset, byte_ready} !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL len65_error: got %b required 1010", {err, busy, cpu_reset, byte_ready});
    end
  endtask

  task automatic test_full_depth;
    bit ok;
    logic [31:0] w;
    clear_log;
    for (int i = 0; i < 64; i++) prog[i] = {8'(i+3), 8'(i+2), 8'(i+1), 8'(i)};
    pulse_start(7'd64);
    send_program(64, 8'h00, 0);
    wait_done(ok);
    vectors++;
    if (!ok || wa.size() != 64) begin
      miscompares++;
      $display("[TB] FAIL full_depth: done_seen=%0d writes=%0d required 1 and 64", ok, wa.size());
    end
    for (int i = 0; i < 64; i++) begin
      w = {8'(i+3), 8'(i+2), 8'(i+1), 8'(i)};
      vectors++;
      if (((i < wa.size()) ? {wa[i], wd[i]} : 38'hx) !== {6'(i), w}) begin
        miscompares++;
        $display("[TB] FAIL full_word%0d: got %h required %h", i,
                 (i < wa.size()) ? {wa[i], wd[i]} : 38'hx, {6'(i), w});
      end
    end
  endtask

  task automatic test_reset_midword;
    bit ok;
    do_reset; clear_log;
    pulse_start(7'd2);
    send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
    send_byte(8'h88, 0); send_byte(8'h77, 0);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cpu_reset, byte_ready, imem_we, imem_addr, imem_wd, busy, done, err} !==
        {1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL midword_reset: got %h required %h",
               {cpu_reset, byte_ready, imem_we, imem_addr, imem_wd, busy, done, err},
               {1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 3'b000});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (wa.size() != 1 || wd[0] !== 32'h11223344) begin
      miscompares++;
      $display("[TB] FAIL midword_writes: writes=%0d first=%h required 1 and 11223344",
               wa.size(), (wa.size() > 0) ? wd[0] : 32'hx);
    end
    clear_log;
    prog[0] = 32'hA5A50F0F;
    pulse_start(7'd1);
    send_program(1, 8'h00, 0);
    wait_done(ok);
    vectors++;
    if (!ok || wa.size() != 1 || {wa[0], wd[0]} !== {6'd0, 32'hA5A50F0F}) begin
      miscompares++;
      $display("[TB] FAIL reload_after_reset: done_seen=%0d writes=%0d required 1, 1 at addr 0 data a5a50f0f",
               ok, wa.size());
    end
  endtask

  task automatic test_restart_from_run;
    bit ok;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL run_precondition: done=%b required 1", done);
    end
    clear_log;
    prog[0] = 32'hAC020054; prog[1] = 32'h08000011;
    pulse_start(7'd2);
    vectors++;
    if ({cpu_reset, done, busy} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL restart_from_run: got %b required 101", {cpu_reset, done, busy});
    end
    for (int k = 0; k < 6; k++) send_byte(get_byte(k), 0);
    start = 1'b1; len = 7'd0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, byte_ready, done, err} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL start_in_load: got %b required 1100", {busy, byte_ready, done, err});
    end
    for (int k = 6; k < 8; k++) send_byte(get_byte(k), 0);
    send_byte(checksum(2), 0);
    wait_done(ok);
    vectors++;
    if (!ok || wa.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL restart_load: done_seen=%0d writes=%0d required 1 and 2", ok, wa.size());
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (((i < wa.size()) ? {wa[i], wd[i]} : 38'hx) !== {6'(i), prog[i]}) begin
        miscompares++;
        $display("[TB] FAIL restart_word%0d: got %h required %h", i,
                 (i < wa.size()) ? {wa[i], wd[i]} : 38'hx, {6'(i), prog[i]});
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_bad_checksum;
    test_random_valid;
    test_len_zero;
    test_len_overflow;
    test_full_depth;
    test_reset_midword;
    test_restart_from_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
